fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 82 ++++++++
 tb/tb_fifo_wr_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Four-requester round-robin write arbiter in front of a FIFO write port.
// A grant holds a requester for up to MAX_BURST writes, then the next requester gets a turn.
module fifo_wr_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  w_clk,
  input  logic                  rstN,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  w_full,
  output logic [3:0]            gnt,
  output logic                  w_en,
  output logic [DATA_W-1:0]     w_data,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  logic [0:0] state;
  logic [1:0] gnt_idx;
  logic [1:0] rr_ptr;
  logic [3:0] burst_cnt;
  logic [1:0] pick;
  logic [1:0] cand;

  // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    pick = rr_ptr;
    cand = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (req[cand]) pick = cand;
    end
  end

  // Write handshake: a write is accepted on any rising edge where w_en = 1.
  // w_en is the "valid", w_full is the inverted "ready"; w_en already has w_full folded in.
  assign busy      = (state == ST_BURST);
  assign state_dbg = state[0];
  assign w_en      = busy & req[gnt_idx] & ~w_full;
  assign w_data    = busy ? req_data[32'(gnt_idx)*DATA_W +: DATA_W] : '0;

  always_ff @(posedge w_clk or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      rr_ptr    <= 2'd0;
      burst_cnt <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req != 4'b0000) begin
            state     <= ST_BURST;
            gnt       <= 4'b0001 << pick;
            gnt_idx   <= pick;
            burst_cnt <= 4'd0;
          end
        end
        ST_BURST: begin
          if (!req[gnt_idx] || (w_en && burst_cnt == LAST_CNT)) begin
            state     <= ST_IDLE;
            gnt       <= 4'b0000;
            rr_ptr    <= gnt_idx + 2'd1;
            burst_cnt <= 4'd0;
          end else if (w_en) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: writes are checked against a queue of expected data,
// grant/enable/busy are checked at each step of the scenarios.
module tb_fifo_wr_arb;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            w_clk = 1'b0;
  logic            rstN  = 1'b0;
  logic [3:0]      req   = 4'b0000;
  logic [4*DW-1:0] req_data = '0;
  logic            w_full = 1'b0;
  logic [3:0]      gnt;
  logic            w_en;
  logic [DW-1:0]   w_data;
  logic            busy;
  logic            state_dbg;

  logic [DW-1:0]   exp_q[$];
  int              n_pass  = 0;
  int              n_total = 0;
  int              n_wr    = 0;
  int              wr_mark = 0;

  fifo_wr_arb #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .w_clk     (w_clk),
    .rstN      (rstN),
    .req       (req),
    .req_data  (req_data),
    .w_full    (w_full),
    .gnt       (gnt),
    .w_en      (w_en),
    .w_data    (w_data),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_gnt, input logic e_wen,
                           input logic e_busy);
    check({tag, "_gnt"},  32'(gnt),       32'(e_gnt));
    check({tag, "_wen"},  32'(w_en),      32'(e_wen));
    check({tag, "_busy"}, 32'(busy),      32'(e_busy));
    check({tag, "_dbg"},  32'(state_dbg), 32'(e_busy));
  endtask

  // driver tasks: inputs change just after the rising edge, outputs are sampled on the falling edge
  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge w_clk);
  endtask

  function automatic logic [DW-1:0] slice(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic new_data();
    for (int i = 0; i < 4; i++)
      req_data[i*DW +: DW] = DW'(i*64 + $urandom_range(0, 63));
  endtask

  task automatic push_writes(input int i, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(slice(i));
  endtask

  // scoreboard: every write seen on the FIFO port pops one expected data word
  always @(negedge w_clk) begin
    logic [DW-1:0] e;
    if (rstN) begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("wen_while_full", 32'(w_en && w_full), 32'd0);
      if (w_en) begin
        n_wr++;
        check("q_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("w_data", 32'(w_data), 32'(e));
        end
      end
    end
  end

  initial begin
    // reset state, with requests already present
    req = 4'b1111;
    new_data();
    smp();
    check_out("reset", 4'b0000, 1'b0, 1'b0);
    check("reset_wdata", 32'(w_data), 32'd0);

    // single requester, full burst
    cyc();
    rstN = 1'b1;
    req  = 4'b0001;
    smp();
    check_out("a_arb", 4'b0000, 1'b0, 1'b0);
    push_writes(0, MB);
    for (int i = 0; i < MB; i++) begin
      cyc();
      smp();
      check_out("a_burst", 4'b0001, 1'b1, 1'b1);
    end
    cyc();
    req = 4'b0000;
    smp();
    check_out("a_done", 4'b0000, 1'b0, 1'b0);
    check("a_q_empty", 32'(exp_q.size()), 32'd0);

    // all requesting: round robin 0,1,2,3,0 with one idle cycle between bursts
    cyc();
    rstN = 1'b0;
    cyc();
    rstN = 1'b1;
    new_data();
    cyc();
    req = 4'b1111;
    wr_mark = n_wr;
    for (int c = 0; c < 25; c++) begin
      if (c > 0) cyc();
      if (c % 5 == 0) begin
        smp();
        check_out("b_arb", 4'b0000, 1'b0, 1'b0);
        if (c == 20) check("b_writes_20", 32'(n_wr - wr_mark), 32'd16);
      end else begin
        push_writes((c / 5) % 4, 1);
        smp();
        check_out("b_burst", 4'b0001 << ((c / 5) % 4), 1'b1, 1'b1);
      end
    end
    cyc();
    req = 4'b0000;
    smp();
    check_out("b_done", 4'b0000, 1'b0, 1'b0);
    check("b_q_empty", 32'(exp_q.size()), 32'd0);

    // requester 2 stalled by w_full after two writes; others toggle meanwhile
    new_data();
    cyc();
    req = 4'b0100;
    push_writes(2, MB);
    smp();
    check_out("c_arb", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      smp();
      check_out("c_pre", 4'b0100, 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      w_full = 1'b1;
      req    = (i == 1) ? 4'b1111 : 4'b0111;
      smp();
      check_out("c_stall", 4'b0100, 1'b0, 1'b1);
      check("c_stall_wdata", 32'(w_data), 32'(slice(2)));
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      w_full = 1'b0;
      req    = 4'b0100;
      smp();
      check_out("c_post", 4'b0100, 1'b1, 1'b1);
    end
    cyc();
    req = 4'b0000;
    smp();
    check_out("c_done", 4'b0000, 1'b0, 1'b0);
    check("c_q_empty", 32'(exp_q.size()), 32'd0);

    // requester 1 drops its request after one write; pointer moves to 2
    new_data();
    cyc();
    req = 4'b0010;
    push_writes(1, 1);
    wr_mark = n_wr;
    smp();
    check_out("d_arb", 4'b0000, 1'b0, 1'b0);
    cyc();
    smp();
    check_out("d_write", 4'b0010, 1'b1, 1'b1);
    cyc();
    req = 4'b0000;
    smp();
    check_out("d_drop", 4'b0010, 1'b0, 1'b1);
    cyc();
    req = 4'b0011;
    smp();
    check_out("d_idle", 4'b0000, 1'b0, 1'b0);
    check("d_writes", 32'(n_wr - wr_mark), 32'd1);
    push_writes(0, MB);
    for (int i = 0; i < MB; i++) begin
      cyc();
      smp();
      check_out("d_next", 4'b0001, 1'b1, 1'b1);
    end
    cyc();
    req = 4'b0000;
    smp();
    check_out("d_done", 4'b0000, 1'b0, 1'b0);
    check("d_q_empty", 32'(exp_q.size()), 32'd0);

    // asynchronous reset during the third write of a burst
    new_data();
    cyc();
    req = 4'b0001;
    push_writes(0, 3);
    smp();
    check_out("e_arb", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      smp();
      check_out("e_burst", 4'b0001, 1'b1, 1'b1);
    end
    #2;
    rstN = 1'b0;
    #1;
    check_out("e_async_rst", 4'b0000, 1'b0, 1'b0);
    check("e_rst_wdata", 32'(w_data), 32'd0);
    cyc();
    rstN = 1'b1;
    req  = 4'b1000;
    push_writes(3, MB);
    smp();
    check_out("e_arb2", 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < MB; i++) begin
      cyc();
      smp();
      check_out("e_burst2", 4'b1000, 1'b1, 1'b1);
    end
    cyc();
    req = 4'b0000;
    smp();
    check_out("e_done", 4'b0000, 1'b0, 1'b0);
    check("e_q_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
